// File: rtl/mips_mem_arbiter.sv
// Two-requester arbiter sharing one Avalon-style memory port between instruction fetch and data access.
// Define MIPS_MEM_ARBITER_ROUND_ROBIN_EN to replace fixed data-first priority with round-robin.
module mips_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_ack,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_ack,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic [ADDR_WIDTH-1:0]   m_address,
  output logic                    m_read,
  output logic                    m_write,
  output logic [DATA_WIDTH-1:0]   m_writedata,
  output logic [DATA_WIDTH/8-1:0] m_byteenable,
  input  logic [DATA_WIDTH-1:0]   m_readdata,
  input  logic                    m_waitrequest,
  output logic                    busy
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mAddress_q, mAddress_d;
  logic                  mRead_q, mRead_d;
  logic                  mWrite_q, mWrite_d;
  logic [DATA_WIDTH-1:0] mWritedata_q, mWritedata_d;
  logic [BE_WIDTH-1:0]   mByteenable_q, mByteenable_d;
  logic                  iAck_q, iAck_d;
  logic                  dAck_q, dAck_d;
  logic [DATA_WIDTH-1:0] iRdata_q, iRdata_d;
  logic [DATA_WIDTH-1:0] dRdata_q, dRdata_d;
  logic                  busy_q, busy_d;
  logic                  iElig, dElig, grantD, grantI;

`ifdef MIPS_MEM_ARBITER_ROUND_ROBIN_EN
  // 0 = instruction was granted last, 1 = data was granted last
  logic lastGrant_q, lastGrant_d;
`endif

  // A requester whose ack is currently high is still holding its old request
  assign iElig = i_req && !iAck_q;
  assign dElig = d_req && !dAck_q;

`ifdef MIPS_MEM_ARBITER_ROUND_ROBIN_EN
  assign grantD = dElig && (!iElig || !lastGrant_q);
`else
  assign grantD = dElig;
`endif
  assign grantI = iElig && !grantD;

  always_comb begin
    state_d       = state_q;
    mAddress_d    = mAddress_q;
    mRead_d       = mRead_q;
    mWrite_d      = mWrite_q;
    mWritedata_d  = mWritedata_q;
    mByteenable_d = mByteenable_q;
    iRdata_d      = iRdata_q;
    dRdata_d      = dRdata_q;
    iAck_d        = 1'b0;
    dAck_d        = 1'b0;
`ifdef MIPS_MEM_ARBITER_ROUND_ROBIN_EN
    lastGrant_d   = lastGrant_q;
`endif
    case (state_q)
      IDLE: begin
        if (grantD) begin
          mAddress_d    = d_addr;
          mWritedata_d  = d_wdata;
          mByteenable_d = d_be;
          mWrite_d      = d_we;
          mRead_d       = !d_we;
          state_d       = GNT_D;
`ifdef MIPS_MEM_ARBITER_ROUND_ROBIN_EN
          lastGrant_d   = 1'b1;
`endif
        end else if (grantI) begin
          mAddress_d    = i_addr;
          mWritedata_d  = '0;
          mByteenable_d = {BE_WIDTH{1'b1}};
          mWrite_d      = 1'b0;
          mRead_d       = 1'b1;
          state_d       = GNT_I;
`ifdef MIPS_MEM_ARBITER_ROUND_ROBIN_EN
          lastGrant_d   = 1'b0;
`endif
        end
      end
      GNT_I: begin
        if (!m_waitrequest) begin
          iRdata_d = m_readdata;
          iAck_d   = 1'b1;
          mRead_d  = 1'b0;
          mWrite_d = 1'b0;
          state_d  = IDLE;
        end
      end
      GNT_D: begin
        if (!m_waitrequest) begin
          if (mRead_q) begin
            dRdata_d = m_readdata;
          end
          dAck_d   = 1'b1;
          mRead_d  = 1'b0;
          mWrite_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        mRead_d  = 1'b0;
        mWrite_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      mAddress_q    <= '0;
      mRead_q       <= 1'b0;
      mWrite_q      <= 1'b0;
      mWritedata_q  <= '0;
      mByteenable_q <= '0;
      iAck_q        <= 1'b0;
      dAck_q        <= 1'b0;
      iRdata_q      <= '0;
      dRdata_q      <= '0;
      busy_q        <= 1'b0;
`ifdef MIPS_MEM_ARBITER_ROUND_ROBIN_EN
      lastGrant_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mAddress_q    <= mAddress_d;
      mRead_q       <= mRead_d;
      mWrite_q      <= mWrite_d;
      mWritedata_q  <= mWritedata_d;
      mByteenable_q <= mByteenable_d;
      iAck_q        <= iAck_d;
      dAck_q        <= dAck_d;
      iRdata_q      <= iRdata_d;
      dRdata_q      <= dRdata_d;
      busy_q        <= busy_d;
`ifdef MIPS_MEM_ARBITER_ROUND_ROBIN_EN
      lastGrant_q   <= lastGrant_d;
`endif
    end
  end

  assign m_address    = mAddress_q;
  assign m_read       = mRead_q;
  assign m_write      = mWrite_q;
  assign m_writedata  = mWritedata_q;
  assign m_byteenable = mByteenable_q;
  assign i_ack        = iAck_q;
  assign d_ack        = dAck_q;
  assign i_rdata      = iRdata_q;
  assign d_rdata      = dRdata_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed testbench for mips_mem_arbiter with hand-computed expected values.
module tb_mips_mem_arbiter;

`ifdef MIPS_MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic [31:0] m_readdata;
  logic        m_waitrequest;
  logic        busy;

  int assertCount = 0;
  int failCount   = 0;

  mips_mem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_ack        (i_ack),
    .i_rdata      (i_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_be         (d_be),
    .d_ack        (d_ack),
    .d_rdata      (d_rdata),
    .m_address    (m_address),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_writedata  (m_writedata),
    .m_byteenable (m_byteenable),
    .m_readdata   (m_readdata),
    .m_waitrequest(m_waitrequest),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr, input logic dReq,
                               input logic dWe, input logic [31:0] dAddr,
                               input logic [31:0] dWdata, input logic [3:0] dBe);
    i_req   = iReq;
    i_addr  = iAddr;
    d_req   = dReq;
    d_we    = dWe;
    d_addr  = dAddr;
    d_wdata = dWdata;
    d_be    = dBe;
  endtask

  // Advance to just after the next rising edge so outputs are settled
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] firstAddr, secondAddr;
  logic        firstIsData;

  initial begin
    reset         = 1'b0;
    m_readdata    = 32'h0;
    m_waitrequest = 1'b0;
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    repeat (3) waitCycle();
    checkOutput("rst_m_read", m_read, 0);
    checkOutput("rst_m_write", m_write, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_i_ack", i_ack, 0);
    checkOutput("rst_d_ack", d_ack, 0);
    checkOutput("rst_m_address", m_address, 0);
    checkOutput("rst_m_be", m_byteenable, 0);

    // Single instruction fetch, no stall
    reset      = 1'b1;
    m_readdata = 32'h12345678;
    applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    waitCycle();
    checkOutput("if_m_read", m_read, 1);
    checkOutput("if_m_address", m_address, 32'hBFC00000);
    checkOutput("if_m_be", m_byteenable, 4'hF);
    checkOutput("if_busy", busy, 1);
    checkOutput("if_i_ack_early", i_ack, 0);
    waitCycle();
    checkOutput("if_i_ack", i_ack, 1);
    checkOutput("if_i_rdata", i_rdata, 32'h12345678);
    checkOutput("if_m_read_clr", m_read, 0);
    checkOutput("if_busy_clr", busy, 0);
    i_req = 1'b0;
    waitCycle();
    checkOutput("if_i_ack_one", i_ack, 0);

    // Contended: last grant was instruction, so data wins in both modes
    m_readdata = 32'hAAAA0001;
    applyStimulus(1'b1, 32'hBFC00004, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hF);
    waitCycle();
    checkOutput("ct_first_addr", m_address, 32'h1000);
    checkOutput("ct_first_read", m_read, 1);
    waitCycle();
    checkOutput("ct_d_ack", d_ack, 1);
    checkOutput("ct_i_ack_excl", i_ack, 0);
    checkOutput("ct_d_rdata", d_rdata, 32'hAAAA0001);
    d_req = 1'b0;
    m_readdata = 32'hCCCC0002;
    waitCycle();
    checkOutput("ct_second_addr", m_address, 32'hBFC00004);
    checkOutput("ct_second_read", m_read, 1);
    checkOutput("ct_d_ack_one", d_ack, 0);
    waitCycle();
    checkOutput("ct_i_ack", i_ack, 1);
    checkOutput("ct_i_rdata", i_rdata, 32'hCCCC0002);
    i_req = 1'b0;
    waitCycle();

    // Data read stalled three cycles; readdata is junk until waitrequest drops
    m_waitrequest = 1'b1;
    m_readdata    = 32'hBAD0BAD0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF);
    waitCycle();
    for (int k = 0; k < 4; k++) begin
      checkOutput("st_m_read", m_read, 1);
      checkOutput("st_m_address", m_address, 32'h3000);
      checkOutput("st_m_be", m_byteenable, 4'hF);
      checkOutput("st_d_ack_low", d_ack, 0);
      if (k == 3) begin
        m_waitrequest = 1'b0;
        m_readdata    = 32'h55555555;
      end
      waitCycle();
    end
    checkOutput("st_d_ack", d_ack, 1);
    checkOutput("st_d_rdata", d_rdata, 32'h55555555);
    d_req = 1'b0;
    waitCycle();
    checkOutput("st_d_ack_one", d_ack, 0);

    // Partial-byte write; load data must be left untouched
    m_readdata = 32'h99999999;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011);
    waitCycle();
    checkOutput("wr_m_write", m_write, 1);
    checkOutput("wr_m_read", m_read, 0);
    checkOutput("wr_m_address", m_address, 32'h2000);
    checkOutput("wr_m_wdata", m_writedata, 32'hDEADBEEF);
    checkOutput("wr_m_be", m_byteenable, 4'b0011);
    waitCycle();
    checkOutput("wr_d_ack", d_ack, 1);
    checkOutput("wr_d_rdata", d_rdata, 32'h55555555);
    checkOutput("wr_m_write_clr", m_write, 0);
    d_req = 1'b0;
    waitCycle();

    // Contended after a data grant: round-robin picks instruction, fixed picks data
    firstIsData = !RR_EN;
    firstAddr   = firstIsData ? 32'h4000 : 32'hBFC00008;
    secondAddr  = firstIsData ? 32'hBFC00008 : 32'h4000;
    m_readdata  = 32'h77777777;
    applyStimulus(1'b1, 32'hBFC00008, 1'b1, 1'b0, 32'h4000, 32'h0, 4'hF);
    waitCycle();
    checkOutput("rr_first_addr", m_address, firstAddr);
    waitCycle();
    checkOutput("rr_first_d_ack", d_ack, firstIsData);
    checkOutput("rr_first_i_ack", i_ack, !firstIsData);
    if (firstIsData) d_req = 1'b0;
    else i_req = 1'b0;
    m_readdata = 32'h88888888;
    waitCycle();
    checkOutput("rr_second_addr", m_address, secondAddr);
    waitCycle();
    checkOutput("rr_second_d_ack", d_ack, !firstIsData);
    checkOutput("rr_second_i_ack", i_ack, firstIsData);
    i_req = 1'b0;
    d_req = 1'b0;
    waitCycle();

    // Reset while a data write is stalled
    m_waitrequest = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h5000, 32'h11112222, 4'hF);
    waitCycle();
    checkOutput("ra_m_write", m_write, 1);
    waitCycle();
    checkOutput("ra_m_write_held", m_write, 1);
    reset = 1'b0;
    waitCycle();
    checkOutput("ra_m_write_clr", m_write, 0);
    checkOutput("ra_m_read_clr", m_read, 0);
    checkOutput("ra_busy_clr", busy, 0);
    checkOutput("ra_d_ack", d_ack, 0);
    reset         = 1'b1;
    d_req         = 1'b0;
    m_waitrequest = 1'b0;
    waitCycle();
    checkOutput("ra_d_ack_after", d_ack, 0);
    checkOutput("ra_busy_after", busy, 0);
    m_readdata = 32'h13579BDF;
    applyStimulus(1'b1, 32'hBFC00010, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    waitCycle();
    checkOutput("ra_if_read", m_read, 1);
    checkOutput("ra_if_addr", m_address, 32'hBFC00010);
    waitCycle();
    checkOutput("ra_if_ack", i_ack, 1);
    checkOutput("ra_if_rdata", i_rdata, 32'h13579BDF);
    i_req = 1'b0;
    waitCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
